// File: rtl/pipeline_pkg.sv
// Shared types for the pulse/pipeline wrapper pair: skid-buffer occupancy
// states and the buffer depth.
package pipeline_pkg;

   localparam int SKID_DEPTH = 2;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } buffer_state_t;

endpackage

// File: rtl/pulse_latch_set_clear.sv
// Single-bit flag with priority clear, then lower, then raise; else hold.
// Holds the "module idle" state between a module_ready pulse and the next issue.
module pulse_latch_set_clear #(
   parameter bit INIT = 1'b1
) (
   input  logic clock,
   input  logic clear,
   input  logic i_lower,
   input  logic i_raise,
   output logic o_q
);

   logic r_q;

   always_ff @(posedge clock) begin
      if (clear)        r_q <= INIT;
      else if (i_lower) r_q <= 1'b0;
      else if (i_raise) r_q <= 1'b1;
   end

   assign o_q = r_q;

endmodule

// File: rtl/pipeline_to_pulse.sv
// Ready/valid to one-cycle pulse adapter with a 2-entry skid buffer and bypass.
// Optional protocol checker: define PIPELINE_TO_PULSE_PROTOCOL_CHECK_EN.
module pipeline_to_pulse
   import pipeline_pkg::*;
#(
   parameter int WORD_WIDTH    = 32,
   parameter bit INITIAL_READY = 1'b1
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  valid_in,
   output logic                  ready_in,
   input  logic [WORD_WIDTH-1:0] data_in,
   output logic [WORD_WIDTH-1:0] module_data_in,
   output logic                  module_data_in_valid,
   input  logic                  module_ready
`ifdef PIPELINE_TO_PULSE_PROTOCOL_CHECK_EN
   ,
   output logic                  protocol_error
`endif
);

   buffer_state_t         r_state;
   logic [WORD_WIDTH-1:0] r_head;
   logic [WORD_WIDTH-1:0] r_tail;
   logic                  r_ready_in;
   logic [WORD_WIDTH-1:0] r_out_data;
   logic                  r_out_valid;

   buffer_state_t         w_state_next;
   logic                  w_accept;
   logic                  w_avail;
   logic                  w_idle;
   logic                  w_issue;
   logic [WORD_WIDTH-1:0] w_word;

   assign w_accept = valid_in && r_ready_in;
   assign w_avail  = (r_state != EMPTY) || w_accept;
   // An empty buffer issues the incoming word directly, saving a cycle.
   assign w_word   = (r_state == EMPTY) ? data_in : r_head;
   // module_ready grants an issue in its own cycle, not only via the idle flag.
   assign w_issue  = w_avail && (w_idle || module_ready);

   pulse_latch_set_clear #(
      .INIT (INITIAL_READY)
   ) u_idle (
      .clock   (clock),
      .clear   (clear),
      .i_lower (w_issue),
      .i_raise (module_ready),
      .o_q     (w_idle)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         EMPTY:   if (w_accept && !w_issue) w_state_next = HALF;
         HALF:    if (w_accept && !w_issue)      w_state_next = FULL;
                  else if (!w_accept && w_issue) w_state_next = EMPTY;
         FULL:    if (w_issue) w_state_next = HALF;
         default: w_state_next = EMPTY;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         r_state     <= EMPTY;
         r_ready_in  <= 1'b1;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
      end else begin
         r_state     <= w_state_next;
         r_ready_in  <= (w_state_next != FULL);
         r_out_valid <= w_issue;
         if (w_issue) r_out_data <= w_word;
      end
   end

   // NOTE: buffer storage carries no reset; r_state alone says which entries are live.
   always_ff @(posedge clock) begin
      case (r_state)
         EMPTY:   if (w_accept && !w_issue) r_head <= data_in;
         HALF:    if (w_accept && w_issue) r_head <= data_in;
                  else if (w_accept)       r_tail <= data_in;
         FULL:    if (w_issue) r_head <= r_tail;
         default: ;
      endcase
   end

   assign ready_in             = r_ready_in;
   assign module_data_in       = r_out_data;
   assign module_data_in_valid = r_out_valid;

`ifdef PIPELINE_TO_PULSE_PROTOCOL_CHECK_EN
   logic                  r_error;
   logic                  r_stalled;
   logic [WORD_WIDTH-1:0] r_prev_data;
   logic                  w_idle_misuse;
   logic                  w_hold_break;

   // A stalled upstream word must stay valid and unchanged until accepted.
   assign w_idle_misuse = module_ready && w_idle && !w_issue;
   assign w_hold_break  = r_stalled && (!valid_in || (data_in != r_prev_data));

   always_ff @(posedge clock) begin
      if (clear) begin
         r_error   <= 1'b0;
         r_stalled <= 1'b0;
      end else begin
         r_stalled <= valid_in && !r_ready_in;
         if (w_idle_misuse || w_hold_break) r_error <= 1'b1;
      end
   end

   always_ff @(posedge clock) r_prev_data <= data_in;

   assign protocol_error = r_error;

`ifndef SYNTHESIS
   always_ff @(posedge clock) begin
      if (!clear) begin
         assert (!w_idle_misuse) else $error("module_ready while already idle");
         assert (!w_hold_break)  else $error("upstream word changed while stalled");
      end
   end
`endif
`endif

endmodule

// File: tb/tb_pipeline_to_pulse.sv
// Scoreboard bench for pipeline_to_pulse: a queue-based model predicts pulses,
// ready_in and held data; a separate monitor compares at the falling edge.
module tb_pipeline_to_pulse;
   import pipeline_pkg::*;

   localparam int W          = 32;
   localparam bit INIT_READY = 1'b1;

   logic         clock = 1'b0;
   logic         clear, valid_in, ready_in, module_data_in_valid, module_ready;
   logic [W-1:0] data_in, module_data_in;
`ifdef PIPELINE_TO_PULSE_PROTOCOL_CHECK_EN
   logic         protocol_error;
`endif

   always #5 clock = ~clock;

   pipeline_to_pulse #(
      .WORD_WIDTH    (W),
      .INITIAL_READY (INIT_READY)
   ) dut (
      .clock                (clock),
      .clear                (clear),
      .valid_in             (valid_in),
      .ready_in             (ready_in),
      .data_in              (data_in),
      .module_data_in       (module_data_in),
      .module_data_in_valid (module_data_in_valid),
      .module_ready         (module_ready)
`ifdef PIPELINE_TO_PULSE_PROTOCOL_CHECK_EN
      ,
      .protocol_error       (protocol_error)
`endif
   );

   typedef struct {
      logic [W-1:0] word;
      int           cyc;
   } exp_t;

   exp_t         sb[$];
   exp_t         e;
   logic [W-1:0] m_q[$];
   logic [W-1:0] src[$];
   int           pulses[$];
   bit           m_idle, m_ready, last_acc, mon_en, exp_v;
   logic [W-1:0] exp_data;
   int           cyc = 0;
   int           last_pulse = -100;
   int           last_edge = 0;
   int           auto_mr_delay = 0;
   int           n_checks = 0;
   int           n_pass = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Monitor: compares what the DUT presents against the model's predictions.
   initial begin
      forever begin
         @(negedge clock);
         if (mon_en) begin
            exp_v = (sb.size() > 0) && (sb[0].cyc == cyc);
            check("pulse_valid", W'(module_data_in_valid), W'(exp_v));
            check("ready_in", W'(ready_in), W'(m_ready));
            check("data_hold", module_data_in, exp_data);
            if (exp_v) begin
               e = sb.pop_front();
               check("pulse_data", module_data_in, e.word);
            end
            if (module_data_in_valid) begin
               pulses.push_back(cyc);
               last_pulse = cyc;
            end
         end
      end
   end

   // Drive one cycle of inputs and advance the model across the coming edge.
   task automatic drive(input bit clr, input bit v, input logic [W-1:0] d, input bit mr);
      bit mr_eff;
      @(negedge clock);
      #1;
      mr_eff = mr || (auto_mr_delay > 0 && cyc == last_pulse + auto_mr_delay);
      clear = clr; valid_in = v; data_in = d; module_ready = mr_eff;
      last_edge = cyc + 1;
      last_acc  = 1'b0;
      if (clr) begin
         m_q.delete();
         m_idle   = INIT_READY;
         m_ready  = 1'b1;
         exp_data = '0;
      end else begin
         last_acc = v && m_ready;
         if (last_acc) m_q.push_back(d);
         if (m_q.size() > 0 && (m_idle || mr_eff)) begin
            exp_data = m_q.pop_front();
            sb.push_back('{word: exp_data, cyc: last_edge});
            m_idle = 1'b0;
         end else if (mr_eff) begin
            m_idle = 1'b1;
         end
         m_ready = (m_q.size() < SKID_DEPTH);
      end
      mon_en = 1'b1;
   endtask

   // Offer words from src, holding each one until it is accepted.
   task automatic stream(input int cycles, input bit mr);
      for (int i = 0; i < cycles; i++) begin
         if (src.size() > 0) drive(1'b0, 1'b1, src[0], mr);
         else                drive(1'b0, 1'b0, '0, mr);
         if (last_acc) void'(src.pop_front());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   int n_before;

   initial begin
      clear = 1'b1; valid_in = 1'b0; data_in = '0; module_ready = 1'b0;

      // Reset, then first word bypasses straight to a pulse.
      drive(1, 0, '0, 0);
      drive(1, 0, '0, 0);
      drive(0, 1, 32'hA5, 0);
      n_before = last_edge;
      drive(0, 0, '0, 0);
      drive(0, 0, '0, 0);
      check("first_latency", W'(last_pulse), W'(n_before));

      // Iterative module answering 3 cycles after each pulse.
      drive(1, 0, '0, 0);
      pulses.delete();
      last_pulse = -100;
      auto_mr_delay = 3;
      src = '{32'h1, 32'h2, 32'h3, 32'h4};
      stream(24, 0);
      auto_mr_delay = 0;
      check("stream_pulses", W'(pulses.size()), W'(4));
      for (int i = 1; i < pulses.size(); i++)
         check("pulse_gap", W'(pulses[i] - pulses[i-1]), W'(4));

      // Module never ready: buffer fills, then one module_ready drains a word.
      drive(1, 0, '0, 0);
      pulses.delete();
      src = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h15};
      stream(8, 0);
      check("stall_pulses", W'(pulses.size()), W'(1));
      stream(1, 1);
      stream(4, 0);
      check("after_ready_pulses", W'(pulses.size()), W'(2));

      // Accept and issue in the same cycle while HALF.
      drive(1, 0, '0, 0);
      src = '{32'h21, 32'h22};
      stream(3, 0);
      drive(0, 1, 32'h23, 1);
      drive(0, 0, '0, 0);

      // Fill to FULL, clear, confirm silence, then a fresh bypass.
      drive(0, 1, 32'h24, 0);
      drive(1, 0, '0, 0);
      n_before = pulses.size();
      repeat (4) drive(0, 0, '0, 0);
      check("no_pulse_after_clear", W'(pulses.size() - n_before), W'(0));
      drive(0, 1, 32'h7E, 0);
      n_before = last_edge;
      drive(0, 0, '0, 0);
      drive(0, 0, '0, 0);
      check("post_clear_latency", W'(last_pulse), W'(n_before));

`ifdef PIPELINE_TO_PULSE_PROTOCOL_CHECK_EN
      drive(1, 0, '0, 0);
      drive(0, 0, '0, 0);
      drive(0, 0, '0, 1);
      drive(0, 0, '0, 0);
      check("protocol_error_set", W'(protocol_error), W'(1));
      drive(0, 0, '0, 0);
      check("protocol_error_sticky", W'(protocol_error), W'(1));
      drive(1, 0, '0, 0);
      drive(0, 0, '0, 0);
      check("protocol_error_clear", W'(protocol_error), W'(0));
`endif

      // Randomized traffic with legal upstream holding and rare clears.
      drive(1, 0, '0, 0);
      src.delete();
      for (int i = 0; i < 800; i++) begin
         bit clr, mr;
         if (src.size() == 0 && $urandom_range(0, 99) < 60) src.push_back($urandom);
         clr = ($urandom_range(0, 149) == 0);
         mr  = ($urandom_range(0, 3) == 0) && !m_idle;
         if (src.size() > 0) drive(clr, 1'b1, src[0], mr);
         else                drive(clr, 1'b0, '0, mr);
         if (last_acc) void'(src.pop_front());
      end

      repeat (3) drive(0, 0, '0, 0);
      check("scoreboard_drained", W'(sb.size()), W'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipeline_to_pulse.md
Name: pipeline_to_pulse

Overview:
- Converts a ready/valid pipeline input into a one-cycle input pulse for a connected iterative module whose initiation interval is greater than 1.
- Issues the next word only after the module signals, with a one-cycle `module_ready` pulse, that it can accept new input.
- Sits in front of such a module. It is the input-side counterpart of the pulse-to-pipeline output wrapper.
- A 2-entry internal skid buffer holds incoming words. `ready_in` is registered, which cuts any combinational path from `module_ready` to `ready_in`.

Parameters:
- WORD_WIDTH, 32, width of the data word.
- INITIAL_READY, 1, state of the "module idle" flag after `clear`. 1 means the module may receive a word immediately after reset.

Ports:
- clock  in  1  sole clock; all logic on the rising edge.
- clear  in  1  synchronous, active-high reset.
- valid_in  in  1  upstream word valid.
- ready_in  out  1  upstream ready; registered.
- data_in  in  WORD_WIDTH  upstream data.
- module_data_in  out  WORD_WIDTH  data to the module; registered, held stable between pulses.
- module_data_in_valid  out  1  one-cycle pulse to the module; registered.
- module_ready  in  1  one-cycle pulse from the module: it can accept the next word.

Behaviour:
- Reset values on `clear`:
  - ready_in=1, module_data_in_valid=0, module_data_in=0.
  - Buffer EMPTY, idle=INITIAL_READY.
- Handshakes:
  - Input accept occurs when valid_in && ready_in at a clock edge.
  - Data is written only on accept.
- Buffer states:
  - EMPTY (0 entries), HALF (1 entry), FULL (2 entries).
  - ready_in is registered as next_state != FULL.
- Idle flag:
  - Priority order: clear, then issue (idle<=0), then module_ready (idle<=1), else hold.
- Issue condition: a word is available (buffer head, or data_in bypass when EMPTY and accepting) && (idle || module_ready).
  - module_ready passes straight through, so no cycle is lost waiting on the idle latch.
- On issue, at the next edge:
  - module_data_in <= issued word.
  - module_data_in_valid <= 1 for exactly one cycle.
  - idle <= 0.
- Latency:
  - Accept in cycle N with EMPTY and idle (or module_ready high) gives the pulse in cycle N+1.
  - Otherwise the pulse comes one cycle after the issue condition becomes true.
- At most one issue per cycle. Consecutive pulses need a module_ready in between, so the minimum spacing is 2 cycles.
- Simultaneous accept and issue: occupancy is unchanged. Buffer order is preserved (FIFO), with no reordering or drop.
- FULL: ready_in=0. An issue in that cycle drops to HALF, and ready_in rises the following cycle.
- module_ready while already idle is treated as idle (no-op). It never grants a second issue.
- module_ready arriving with an empty buffer sets idle. The next accepted word then issues with bypass latency.
- Mid-operation clear discards buffered words and any pending pulse. A pulse already visible that cycle is not retracted; it was driven by the prior edge.

Optional Feature:
- Macro: PIPELINE_TO_PULSE_PROTOCOL_CHECK_EN.
- When defined:
  - Adds output `protocol_error` (1 bit, reset 0), sticky until `clear`.
  - Set on module_ready while idle=1 and no issue occurs that cycle.
  - Set on valid_in dropping, or data_in changing, while valid_in=1 and ready_in=0.
  - Simulation-only assertions mirror both conditions.
- When undefined: no port and no logic. Behaviour is otherwise identical.

Decomposition:
- Shared package pipeline_pkg holds:
  - typedef buffer_state_t {EMPTY, HALF, FULL}.
  - Localparam SKID_DEPTH=2.
- One natural sub-module: pulse_latch_set_clear, the idle flag with clear/set priority. It is reusable by the output-side wrapper.
- The skid buffer stays inline: its issue bypass is specific to this block.

Test Plan:
- Reset: clear high 2 cycles → ready_in=1, module_data_in_valid=0, module_data_in=0. The first word 0xA5 accepted in cycle N → pulse in N+1 with module_data_in=0xA5.
- Iterative module with module_ready 3 cycles after each pulse; upstream streams 0x1,0x2,0x3,0x4 → pulses exactly 4 cycles apart, in order, each 1 cycle wide.
- Module never ready after the first word; upstream streams 5 words → 1 pulse; 2 words buffered; ready_in=0 from the third edge after the first issue. One module_ready → next word issued and ready_in=1 one cycle later.
- module_ready and a new accept in the same cycle while HALF → issue of the head word, occupancy stays HALF, no loss.
- clear asserted while FULL → buffer EMPTY, idle=INITIAL_READY, no further pulses. A new word 0x7E then issues with 1-cycle latency.
- With PIPELINE_TO_PULSE_PROTOCOL_CHECK_EN: module_ready pulse while idle with empty buffer → protocol_error=1 next cycle, held until clear.
